// File: rtl/alu_issue_sched_pkg.sv
// Shared widths, reservation-entry layout and the CDB tag-match helper
// used by the ALU issue scheduler.
package alu_issue_sched_pkg;

    localparam int DATA_WID    = 32;
    localparam int ADDR_WID    = 32;
    localparam int ROB_ID_WID  = 4;
    localparam int OPCODE_WID  = 7;
    localparam int FUNC3_WID   = 3;
    localparam int RS_SIZE_DEF = 8;

    typedef logic [DATA_WID-1:0]   data_t;
    typedef logic [ROB_ID_WID-1:0] rob_t;

    typedef struct packed {
        logic                  busy;
        logic [OPCODE_WID-1:0] opcode;
        logic [FUNC3_WID-1:0]  func3;
        logic                  func1;
        data_t                 v1;
        data_t                 v2;
        rob_t                  q1;
        rob_t                  q2;
        logic                  p1;
        logic                  p2;
        data_t                 imm;
        data_t                 off;
        logic [ADDR_WID-1:0]   pc;
        rob_t                  rob;
    } rs_entry_t;

    typedef struct packed {
        logic  hit;
        data_t data;
    } cdb_hit_t;

    // ALU bus takes priority when both buses carry the same producer tag.
    function automatic cdb_hit_t cdb_lookup(
        input rob_t  tag,
        input logic  alu_v,
        input rob_t  alu_rob,
        input data_t alu_d,
        input logic  lsb_v,
        input rob_t  lsb_rob,
        input data_t lsb_d
    );
        cdb_hit_t r;
        r.hit  = 1'b0;
        r.data = '0;
        if (alu_v && (alu_rob == tag)) begin
            r.hit  = 1'b1;
            r.data = alu_d;
        end else if (lsb_v && (lsb_rob == tag)) begin
            r.hit  = 1'b1;
            r.data = lsb_d;
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_issue_sched_if.sv
// Dispatch, CDB, status and issue signals of the ALU reservation station.
interface alu_issue_sched_if
    import alu_issue_sched_pkg::*;
#(
    parameter int RS_SIZE = RS_SIZE_DEF,
    parameter int ROB_W   = ROB_ID_WID
) ();
    // Dispatch is accepted on a rising edge with disp_valid && !rs_full &&
    // rdy && !rollback; rs_full acts as the inverted ready. CDB valids are
    // single-cycle broadcasts, iss_valid a single-cycle pulse per issue.
    logic                        rdy;
    logic                        rollback;

    logic                        disp_valid;
    logic [OPCODE_WID-1:0]       disp_opcode;
    logic [FUNC3_WID-1:0]        disp_func3;
    logic                        disp_func1;
    logic [DATA_WID-1:0]         disp_imm;
    logic [DATA_WID-1:0]         disp_off;
    logic [ADDR_WID-1:0]         disp_pc;
    logic [ROB_W-1:0]            disp_rob;
    logic                        disp_rdy1;
    logic [DATA_WID-1:0]         disp_val1;
    logic [ROB_W-1:0]            disp_tag1;
    logic                        disp_rdy2;
    logic [DATA_WID-1:0]         disp_val2;
    logic [ROB_W-1:0]            disp_tag2;

    logic                        alu_cdb_valid;
    logic [ROB_W-1:0]            alu_cdb_rob;
    logic [DATA_WID-1:0]         alu_cdb_data;
    logic                        lsb_cdb_valid;
    logic [ROB_W-1:0]            lsb_cdb_rob;
    logic [DATA_WID-1:0]         lsb_cdb_data;

    logic                        rs_full;
    logic [$clog2(RS_SIZE):0]    rs_count;

    logic                        iss_valid;
    logic [OPCODE_WID-1:0]       iss_opcode;
    logic [FUNC3_WID-1:0]        iss_func3;
    logic                        iss_func1;
    logic [DATA_WID-1:0]         iss_data1;
    logic [DATA_WID-1:0]         iss_data2;
    logic [DATA_WID-1:0]         iss_imm;
    logic [DATA_WID-1:0]         iss_off;
    logic [ADDR_WID-1:0]         iss_pc;
    logic [ROB_W-1:0]            iss_rob;

    modport slave (
        input  rdy, rollback,
        input  disp_valid, disp_opcode, disp_func3, disp_func1, disp_imm, disp_off,
        input  disp_pc, disp_rob, disp_rdy1, disp_val1, disp_tag1,
        input  disp_rdy2, disp_val2, disp_tag2,
        input  alu_cdb_valid, alu_cdb_rob, alu_cdb_data,
        input  lsb_cdb_valid, lsb_cdb_rob, lsb_cdb_data,
        output rs_full, rs_count,
        output iss_valid, iss_opcode, iss_func3, iss_func1, iss_data1, iss_data2,
        output iss_imm, iss_off, iss_pc, iss_rob
    );

    modport master (
        output rdy, rollback,
        output disp_valid, disp_opcode, disp_func3, disp_func1, disp_imm, disp_off,
        output disp_pc, disp_rob, disp_rdy1, disp_val1, disp_tag1,
        output disp_rdy2, disp_val2, disp_tag2,
        output alu_cdb_valid, alu_cdb_rob, alu_cdb_data,
        output lsb_cdb_valid, lsb_cdb_rob, lsb_cdb_data,
        input  rs_full, rs_count,
        input  iss_valid, iss_opcode, iss_func3, iss_func1, iss_data1, iss_data2,
        input  iss_imm, iss_off, iss_pc, iss_rob
    );

endinterface

// File: rtl/alu_issue_sched_rs_prio_enc.sv
// Lowest-set-bit priority encoder with a found flag; used for both
// free-slot and eligible-slot selection.
module rs_prio_enc #(
    parameter int N  = 8,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    output logic [IW-1:0] o_idx,
    output logic          o_found
);

    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx   = IW'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_issue_sched.sv
// ALU reservation station: captures dispatched instructions, wakes operands
// from the ALU/LSB CDBs and issues the lowest-index ready entry each cycle.
module alu_issue_sched
    import alu_issue_sched_pkg::*;
#(
    parameter int RS_SIZE = RS_SIZE_DEF,
    parameter int ROB_W   = ROB_ID_WID
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_issue_sched_if.slave   bus
);

    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
    localparam int CNT_W = $clog2(RS_SIZE) + 1;

    rs_entry_t              r_rs [RS_SIZE];
    logic [CNT_W-1:0]       r_count;
    logic                   r_iss_valid;
    logic [OPCODE_WID-1:0]  r_iss_opcode;
    logic [FUNC3_WID-1:0]   r_iss_func3;
    logic                   r_iss_func1;
    data_t                  r_iss_data1;
    data_t                  r_iss_data2;
    data_t                  r_iss_imm;
    data_t                  r_iss_off;
    logic [ADDR_WID-1:0]    r_iss_pc;
    rob_t                   r_iss_rob;

    logic [RS_SIZE-1:0]     w_busy;
    logic [RS_SIZE-1:0]     w_free;
    logic [RS_SIZE-1:0]     w_elig;
    logic [IDX_W-1:0]       w_free_idx;
    logic [IDX_W-1:0]       w_iss_idx;
    logic                   w_free_found;
    logic                   w_elig_found;
    logic                   w_do_disp;
    logic                   w_do_iss;
    logic [ROB_W-1:0]       w_alu_rob;
    logic [ROB_W-1:0]       w_lsb_rob;
    cdb_hit_t               w_src1;
    cdb_hit_t               w_src2;
    cdb_hit_t               w_wk1 [RS_SIZE];
    cdb_hit_t               w_wk2 [RS_SIZE];
    rs_entry_t              w_new;

    assign w_alu_rob = bus.alu_cdb_rob;
    assign w_lsb_rob = bus.lsb_cdb_rob;

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            w_busy[i] = r_rs[i].busy;
            w_free[i] = ~r_rs[i].busy;
            w_elig[i] = r_rs[i].busy & ~r_rs[i].p1 & ~r_rs[i].p2;
            w_wk1[i]  = cdb_lookup(r_rs[i].q1, bus.alu_cdb_valid, w_alu_rob, bus.alu_cdb_data,
                                   bus.lsb_cdb_valid, w_lsb_rob, bus.lsb_cdb_data);
            w_wk2[i]  = cdb_lookup(r_rs[i].q2, bus.alu_cdb_valid, w_alu_rob, bus.alu_cdb_data,
                                   bus.lsb_cdb_valid, w_lsb_rob, bus.lsb_cdb_data);
        end
    end

    rs_prio_enc #(.N(RS_SIZE), .IW(IDX_W)) u_free_enc (
        .i_req   (w_free),
        .o_idx   (w_free_idx),
        .o_found (w_free_found)
    );

    rs_prio_enc #(.N(RS_SIZE), .IW(IDX_W)) u_elig_enc (
        .i_req   (w_elig),
        .o_idx   (w_iss_idx),
        .o_found (w_elig_found)
    );

    // Fullness reflects cycle-start occupancy only; a same-cycle issue does not free a slot.
    assign bus.rs_full = ~w_free_found;
    assign w_do_disp   = bus.disp_valid && w_free_found && bus.rdy && !bus.rollback;
    assign w_do_iss    = w_elig_found && bus.rdy && !bus.rollback;

    always_comb begin
        w_src1 = cdb_lookup(bus.disp_tag1, bus.alu_cdb_valid, w_alu_rob, bus.alu_cdb_data,
                            bus.lsb_cdb_valid, w_lsb_rob, bus.lsb_cdb_data);
        w_src2 = cdb_lookup(bus.disp_tag2, bus.alu_cdb_valid, w_alu_rob, bus.alu_cdb_data,
                            bus.lsb_cdb_valid, w_lsb_rob, bus.lsb_cdb_data);
        w_new        = '0;
        w_new.busy   = 1'b1;
        w_new.opcode = bus.disp_opcode;
        w_new.func3  = bus.disp_func3;
        w_new.func1  = bus.disp_func1;
        w_new.imm    = bus.disp_imm;
        w_new.off    = bus.disp_off;
        w_new.pc     = bus.disp_pc;
        w_new.rob    = bus.disp_rob;
        if (bus.disp_rdy1) begin
            w_new.v1 = bus.disp_val1;
        end else if (w_src1.hit) begin
            w_new.v1 = w_src1.data;
        end else begin
            w_new.p1 = 1'b1;
            w_new.q1 = bus.disp_tag1;
        end
        if (bus.disp_rdy2) begin
            w_new.v2 = bus.disp_val2;
        end else if (w_src2.hit) begin
            w_new.v2 = w_src2.data;
        end else begin
            w_new.p2 = 1'b1;
            w_new.q2 = bus.disp_tag2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                r_rs[i] <= '0;
            end
            r_count      <= '0;
            r_iss_valid  <= 1'b0;
            r_iss_opcode <= '0;
            r_iss_func3  <= '0;
            r_iss_func1  <= 1'b0;
            r_iss_data1  <= '0;
            r_iss_data2  <= '0;
            r_iss_imm    <= '0;
            r_iss_off    <= '0;
            r_iss_pc     <= '0;
            r_iss_rob    <= '0;
        end else if (bus.rdy) begin
            if (bus.rollback) begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    r_rs[i].busy <= 1'b0;
                    r_rs[i].p1   <= 1'b0;
                    r_rs[i].p2   <= 1'b0;
                end
                r_count     <= '0;
                r_iss_valid <= 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (r_rs[i].busy && r_rs[i].p1 && w_wk1[i].hit) begin
                        r_rs[i].v1 <= w_wk1[i].data;
                        r_rs[i].p1 <= 1'b0;
                    end
                    if (r_rs[i].busy && r_rs[i].p2 && w_wk2[i].hit) begin
                        r_rs[i].v2 <= w_wk2[i].data;
                        r_rs[i].p2 <= 1'b0;
                    end
                end
                r_iss_valid <= w_do_iss;
                if (w_do_iss) begin
                    r_rs[w_iss_idx].busy <= 1'b0;
                    r_iss_opcode <= r_rs[w_iss_idx].opcode;
                    r_iss_func3  <= r_rs[w_iss_idx].func3;
                    r_iss_func1  <= r_rs[w_iss_idx].func1;
                    r_iss_data1  <= r_rs[w_iss_idx].v1;
                    r_iss_data2  <= r_rs[w_iss_idx].v2;
                    r_iss_imm    <= r_rs[w_iss_idx].imm;
                    r_iss_off    <= r_rs[w_iss_idx].off;
                    r_iss_pc     <= r_rs[w_iss_idx].pc;
                    r_iss_rob    <= r_rs[w_iss_idx].rob;
                end
                // The free slot was chosen from cycle-start state, so it never aliases the issuing entry.
                if (w_do_disp) begin
                    r_rs[w_free_idx] <= w_new;
                end
                case ({w_do_disp, w_do_iss})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign bus.rs_count   = r_count;
    assign bus.iss_valid  = r_iss_valid;
    assign bus.iss_opcode = r_iss_opcode;
    assign bus.iss_func3  = r_iss_func3;
    assign bus.iss_func1  = r_iss_func1;
    assign bus.iss_data1  = r_iss_data1;
    assign bus.iss_data2  = r_iss_data2;
    assign bus.iss_imm    = r_iss_imm;
    assign bus.iss_off    = r_iss_off;
    assign bus.iss_pc     = r_iss_pc;
    assign bus.iss_rob    = r_iss_rob;

endmodule

// File: tb/tb_alu_issue_sched.sv
// Bench for alu_issue_sched: vector table, directed multi-cycle sequences
// and a randomized run against an array-based reference model.
module tb_alu_issue_sched;

    localparam int RS = 8;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    logic [31:0] exp_q[$];

    alu_issue_sched_if #(.RS_SIZE(RS), .ROB_W(4)) bus ();

    alu_issue_sched #(.RS_SIZE(RS), .ROB_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic idle();
        bus.rdy           = 1'b1;
        bus.rollback      = 1'b0;
        bus.disp_valid    = 1'b0;
        bus.alu_cdb_valid = 1'b0;
        bus.lsb_cdb_valid = 1'b0;
    endtask

    task automatic disp(input logic [6:0] op, input logic [2:0] f3, input logic [3:0] rob,
                        input logic r1, input logic [31:0] v1, input logic [3:0] t1,
                        input logic r2, input logic [31:0] v2, input logic [3:0] t2,
                        input logic [31:0] imm, input logic [31:0] pc);
        bus.disp_valid  = 1'b1;
        bus.disp_opcode = op;
        bus.disp_func3  = f3;
        bus.disp_func1  = f3[0];
        bus.disp_imm    = imm;
        bus.disp_off    = imm ^ pc;
        bus.disp_pc     = pc;
        bus.disp_rob    = rob;
        bus.disp_rdy1   = r1;
        bus.disp_val1   = v1;
        bus.disp_tag1   = t1;
        bus.disp_rdy2   = r2;
        bus.disp_val2   = v2;
        bus.disp_tag2   = t2;
    endtask

    task automatic alu_cdb(input logic [3:0] rob, input logic [31:0] d);
        bus.alu_cdb_valid = 1'b1;
        bus.alu_cdb_rob   = rob;
        bus.alu_cdb_data  = d;
    endtask

    task automatic lsb_cdb(input logic [3:0] rob, input logic [31:0] d);
        bus.lsb_cdb_valid = 1'b1;
        bus.lsb_cdb_rob   = rob;
        bus.lsb_cdb_data  = d;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // ---------------- reference model ----------------
    logic        m_busy [RS];
    logic        m_p1   [RS];
    logic        m_p2   [RS];
    logic [3:0]  m_q1   [RS];
    logic [3:0]  m_q2   [RS];
    logic [3:0]  m_rob  [RS];
    logic [31:0] m_v1   [RS];
    logic [31:0] m_v2   [RS];
    logic [31:0] m_imm  [RS];
    logic [31:0] m_pc   [RS];
    logic        m_iss_v;
    logic [3:0]  m_iss_rob;
    logic [31:0] m_iss_d2;
    logic [31:0] m_iss_imm;
    logic [31:0] m_iss_pc;

    task automatic model_clear();
        for (int i = 0; i < RS; i++) begin
            m_busy[i] = 1'b0;
            m_p1[i]   = 1'b0;
            m_p2[i]   = 1'b0;
        end
        m_iss_v = 1'b0;
        exp_q.delete();
    endtask

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < RS; i++) if (m_busy[i]) n++;
        return n;
    endfunction

    task automatic cdb_find(input logic [3:0] tag, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
        if (bus.alu_cdb_valid && bus.alu_cdb_rob == tag) begin
            hit = 1'b1;
            d   = bus.alu_cdb_data;
        end else if (bus.lsb_cdb_valid && bus.lsb_cdb_rob == tag) begin
            hit = 1'b1;
            d   = bus.lsb_cdb_data;
        end
    endtask

    // One clock edge worth of behaviour, evaluated from the inputs about to be sampled.
    task automatic model_edge();
        int          iss_i;
        int          free_i;
        int          n_busy;
        logic        hit;
        logic [31:0] d;
        if (!bus.rdy) return;
        if (bus.rollback) begin
            for (int i = 0; i < RS; i++) m_busy[i] = 1'b0;
            m_iss_v = 1'b0;
            return;
        end
        n_busy = model_count();
        iss_i  = -1;
        free_i = -1;
        for (int i = 0; i < RS; i++) begin
            if (m_busy[i] && !m_p1[i] && !m_p2[i] && iss_i < 0) iss_i = i;
            if (!m_busy[i] && free_i < 0) free_i = i;
        end
        for (int i = 0; i < RS; i++) begin
            if (m_busy[i] && m_p1[i]) begin
                cdb_find(m_q1[i], hit, d);
                if (hit) begin m_v1[i] = d; m_p1[i] = 1'b0; end
            end
            if (m_busy[i] && m_p2[i]) begin
                cdb_find(m_q2[i], hit, d);
                if (hit) begin m_v2[i] = d; m_p2[i] = 1'b0; end
            end
        end
        m_iss_v = (iss_i >= 0);
        if (iss_i >= 0) begin
            exp_q.push_back(m_v1[iss_i]);
            m_iss_rob = m_rob[iss_i];
            m_iss_d2  = m_v2[iss_i];
            m_iss_imm = m_imm[iss_i];
            m_iss_pc  = m_pc[iss_i];
            m_busy[iss_i] = 1'b0;
        end
        if (bus.disp_valid && n_busy < RS) begin
            m_busy[free_i] = 1'b1;
            m_rob[free_i]  = bus.disp_rob;
            m_imm[free_i]  = bus.disp_imm;
            m_pc[free_i]   = bus.disp_pc;
            m_v1[free_i]   = bus.disp_val1;
            m_p1[free_i]   = 1'b0;
            m_q1[free_i]   = bus.disp_tag1;
            if (!bus.disp_rdy1) begin
                cdb_find(bus.disp_tag1, hit, d);
                m_v1[free_i] = d;
                m_p1[free_i] = !hit;
            end
            m_v2[free_i] = bus.disp_val2;
            m_p2[free_i] = 1'b0;
            m_q2[free_i] = bus.disp_tag2;
            if (!bus.disp_rdy2) begin
                cdb_find(bus.disp_tag2, hit, d);
                m_v2[free_i] = d;
                m_p2[free_i] = !hit;
            end
        end
    endtask

    // ---------------- vector table ----------------
    // mode: 0 operand ready, 1 ALU bypass, 2 LSB bypass, 3 both buses match (ALU wins)
    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [3:0]  rob;
        logic [1:0]  mode;
        logic [31:0] val1;
        logic [31:0] val2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] alu_d;
        logic [31:0] lsb_d;
        logic [31:0] exp_d1;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [31:0] e;
        n_tests = 0;
        n_fail  = 0;
        bus.disp_opcode = '0; bus.disp_func3 = '0; bus.disp_func1 = 1'b0;
        bus.disp_imm = '0; bus.disp_off = '0; bus.disp_pc = '0; bus.disp_rob = '0;
        bus.disp_rdy1 = 1'b0; bus.disp_val1 = '0; bus.disp_tag1 = '0;
        bus.disp_rdy2 = 1'b0; bus.disp_val2 = '0; bus.disp_tag2 = '0;
        bus.alu_cdb_rob = '0; bus.alu_cdb_data = '0;
        bus.lsb_cdb_rob = '0; bus.lsb_cdb_data = '0;

        vecs[0] = '{7'h13, 3'd0, 4'd3,  2'd0, 32'd5,        32'd0,  32'd7,        32'h100, 32'd0,   32'd0,   32'd5};
        vecs[1] = '{7'h33, 3'd4, 4'd7,  2'd0, 32'hFFFFFFFF, 32'd1,  32'd0,        32'h104, 32'd0,   32'd0,   32'hFFFFFFFF};
        vecs[2] = '{7'h13, 3'd1, 4'd5,  2'd2, 32'd0,        32'd9,  32'd3,        32'h108, 32'd0,   32'hAB,  32'hAB};
        vecs[3] = '{7'h33, 3'd7, 4'd9,  2'd1, 32'd0,        32'd2,  32'd0,        32'h10C, 32'h1234, 32'd0,  32'h1234};
        vecs[4] = '{7'h33, 3'd2, 4'd11, 2'd3, 32'd0,        32'd8,  32'd0,        32'h110, 32'h11,  32'h22,  32'h11};
        vecs[5] = '{7'h37, 3'd0, 4'd15, 2'd0, 32'd0,        32'd0,  32'hABCDE000, 32'h114, 32'd0,   32'd0,   32'd0};

        // reset values
        idle();
        rst_n = 1'b0;
        #2;
        chk("rst_count", 32'(bus.rs_count), 32'd0);
        chk("rst_full", 32'(bus.rs_full), 32'd0);
        chk("rst_iss_valid", 32'(bus.iss_valid), 32'd0);
        chk("rst_iss_data1", bus.iss_data1, 32'd0);
        chk("rst_iss_rob", 32'(bus.iss_rob), 32'd0);
        do_reset();

        // single-instruction vectors, incl. dispatch-time CDB bypass
        for (int k = 0; k < 6; k++) begin
            idle();
            disp(vecs[k].op, vecs[k].f3, vecs[k].rob, (vecs[k].mode == 2'd0), vecs[k].val1, 4'd4,
                 1'b1, vecs[k].val2, 4'd0, vecs[k].imm, vecs[k].pc);
            if (vecs[k].mode == 2'd1 || vecs[k].mode == 2'd3) alu_cdb(4'd4, vecs[k].alu_d);
            if (vecs[k].mode == 2'd2 || vecs[k].mode == 2'd3) lsb_cdb(4'd4, vecs[k].lsb_d);
            step();
            chk("vec_count_after_disp", 32'(bus.rs_count), 32'd1);
            chk("vec_iss_valid_early", 32'(bus.iss_valid), 32'd0);
            idle();
            step();
            chk("vec_iss_valid", 32'(bus.iss_valid), 32'd1);
            chk("vec_iss_rob", 32'(bus.iss_rob), 32'(vecs[k].rob));
            chk("vec_iss_data1", bus.iss_data1, vecs[k].exp_d1);
            chk("vec_iss_data2", bus.iss_data2, vecs[k].val2);
            chk("vec_iss_imm", bus.iss_imm, vecs[k].imm);
            chk("vec_iss_pc", bus.iss_pc, vecs[k].pc);
            chk("vec_iss_opcode", 32'(bus.iss_opcode), 32'(vecs[k].op));
            chk("vec_iss_func3", 32'(bus.iss_func3), 32'(vecs[k].f3));
            chk("vec_count_after_iss", 32'(bus.rs_count), 32'd0);
            step();
            chk("vec_iss_pulse", 32'(bus.iss_valid), 32'd0);
        end

        // late wakeup from ALU CDB
        idle();
        disp(7'h33, 3'd0, 4'd2, 1'b0, 32'd0, 4'd1, 1'b1, 32'd3, 4'd0, 32'd0, 32'h200);
        step();
        idle();
        step();
        step();
        chk("wake_wait_count", 32'(bus.rs_count), 32'd1);
        alu_cdb(4'd1, 32'h10);
        step();
        chk("wake_edge_no_issue", 32'(bus.iss_valid), 32'd0);
        idle();
        step();
        chk("wake_iss_valid", 32'(bus.iss_valid), 32'd1);
        chk("wake_iss_data1", bus.iss_data1, 32'h10);
        chk("wake_iss_rob", 32'(bus.iss_rob), 32'd2);

        // fill, full back-pressure, out-of-order wakeup
        for (int i = 0; i < RS; i++) begin
            idle();
            disp(7'h33, 3'd0, 4'(i), 1'b0, 32'd0, 4'(8 + i), 1'b1, 32'(i), 4'd0, 32'd0, 32'(i * 4));
            step();
        end
        chk("fill_full", 32'(bus.rs_full), 32'd1);
        chk("fill_count", 32'(bus.rs_count), 32'd8);
        disp(7'h13, 3'd0, 4'hA, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0, 32'd0, 32'd0);
        step();
        chk("ninth_ignored_count", 32'(bus.rs_count), 32'd8);
        chk("ninth_no_issue", 32'(bus.iss_valid), 32'd0);
        idle();
        lsb_cdb(4'd13, 32'h55);
        step();
        chk("full_wake_no_issue", 32'(bus.iss_valid), 32'd0);
        chk("full_still_full", 32'(bus.rs_full), 32'd1);
        idle();
        step();
        chk("full_iss_valid", 32'(bus.iss_valid), 32'd1);
        chk("full_iss_rob", 32'(bus.iss_rob), 32'd5);
        chk("full_iss_data1", bus.iss_data1, 32'h55);
        chk("full_count_7", 32'(bus.rs_count), 32'd7);
        chk("full_dropped", 32'(bus.rs_full), 32'd0);

        // rollback with an eligible entry and a dispatch in flight
        alu_cdb(4'd8, 32'h66);
        step();
        idle();
        bus.rollback = 1'b1;
        disp(7'h13, 3'd0, 4'd1, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0, 32'd0, 32'd0);
        step();
        chk("rb_count", 32'(bus.rs_count), 32'd0);
        chk("rb_iss_valid", 32'(bus.iss_valid), 32'd0);
        chk("rb_full", 32'(bus.rs_full), 32'd0);
        idle();
        alu_cdb(4'd9, 32'h77);
        step();
        idle();
        step();
        chk("rb_late_cdb_iss", 32'(bus.iss_valid), 32'd0);
        chk("rb_late_cdb_count", 32'(bus.rs_count), 32'd0);

        // rdy=0 freeze
        idle();
        disp(7'h33, 3'd0, 4'd6, 1'b0, 32'd0, 4'd7, 1'b1, 32'd0, 4'd0, 32'd0, 32'h300);
        step();
        disp(7'h13, 3'd0, 4'd1, 1'b1, 32'h99, 4'd0, 1'b1, 32'd0, 4'd0, 32'd0, 32'h304);
        step();
        bus.rdy = 1'b0;
        disp(7'h13, 3'd0, 4'd3, 1'b1, 32'h1, 4'd0, 1'b1, 32'd0, 4'd0, 32'd0, 32'h308);
        alu_cdb(4'd7, 32'h77);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("frz_count", 32'(bus.rs_count), 32'd2);
            chk("frz_iss_valid", 32'(bus.iss_valid), 32'd0);
        end
        idle();
        step();
        chk("frz_rel_iss_valid", 32'(bus.iss_valid), 32'd1);
        chk("frz_rel_iss_rob", 32'(bus.iss_rob), 32'd1);
        chk("frz_rel_iss_data1", bus.iss_data1, 32'h99);
        chk("frz_rel_count", 32'(bus.rs_count), 32'd1);
        step();
        chk("frz_cdb_ignored", 32'(bus.iss_valid), 32'd0);
        alu_cdb(4'd7, 32'h77);
        step();
        idle();
        step();
        chk("frz_late_iss_rob", 32'(bus.iss_rob), 32'd6);
        chk("frz_late_iss_data1", bus.iss_data1, 32'h77);

        // reset mid-operation
        idle();
        disp(7'h33, 3'd0, 4'd2, 1'b0, 32'd0, 4'd12, 1'b1, 32'd0, 4'd0, 32'd0, 32'd0);
        step();
        disp(7'h33, 3'd0, 4'd3, 1'b0, 32'd0, 4'd12, 1'b1, 32'd0, 4'd0, 32'd0, 32'd0);
        step();
        idle();
        rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(bus.rs_count), 32'd0);
        chk("arst_full", 32'(bus.rs_full), 32'd0);
        chk("arst_iss_valid", 32'(bus.iss_valid), 32'd0);
        #1;
        rst_n = 1'b1;
        alu_cdb(4'd12, 32'd5);
        step();
        idle();
        step();
        chk("arst_no_issue", 32'(bus.iss_valid), 32'd0);
        chk("arst_count_after", 32'(bus.rs_count), 32'd0);

        // randomized run against the model
        do_reset();
        model_clear();
        for (int c = 0; c < 600; c++) begin
            bus.rdy           = ($urandom_range(0, 7) != 0);
            bus.rollback      = ($urandom_range(0, 39) == 0);
            bus.disp_valid    = ($urandom_range(0, 2) != 0);
            bus.disp_opcode   = 7'($urandom);
            bus.disp_func3    = 3'($urandom);
            bus.disp_func1    = 1'($urandom);
            bus.disp_imm      = $urandom;
            bus.disp_off      = $urandom;
            bus.disp_pc       = $urandom;
            bus.disp_rob      = 4'($urandom_range(0, 15));
            bus.disp_rdy1     = 1'($urandom_range(0, 1));
            bus.disp_val1     = $urandom;
            bus.disp_tag1     = 4'($urandom_range(0, 15));
            bus.disp_rdy2     = 1'($urandom_range(0, 1));
            bus.disp_val2     = $urandom;
            bus.disp_tag2     = 4'($urandom_range(0, 15));
            bus.alu_cdb_valid = ($urandom_range(0, 2) == 0);
            bus.alu_cdb_rob   = 4'($urandom_range(0, 15));
            bus.alu_cdb_data  = $urandom;
            bus.lsb_cdb_valid = ($urandom_range(0, 2) == 0);
            bus.lsb_cdb_rob   = 4'($urandom_range(0, 15));
            bus.lsb_cdb_data  = $urandom;
            model_edge();
            step();
            chk("rnd_count", 32'(bus.rs_count), 32'(model_count()));
            chk("rnd_full", 32'(bus.rs_full), 32'(model_count() == RS));
            chk("rnd_iss_valid", 32'(bus.iss_valid), 32'(m_iss_v));
            if (m_iss_v && bus.rdy && !bus.rollback) begin
                e = exp_q.pop_front();
                if (bus.iss_valid) begin
                    chk("rnd_iss_data1", bus.iss_data1, e);
                    chk("rnd_iss_rob", 32'(bus.iss_rob), 32'(m_iss_rob));
                    chk("rnd_iss_data2", bus.iss_data2, m_iss_d2);
                    chk("rnd_iss_imm", bus.iss_imm, m_iss_imm);
                    chk("rnd_iss_pc", bus.iss_pc, m_iss_pc);
                end
            end
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
